// File: rtl/busy_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : busy_timer_pkg
// Brief    : Shared types and limits for the multi-channel busy timer.
// Revision : 1.0 - initial release
// ============================================================================
package busy_timer_pkg;

    localparam int CW_MIN  = 2;
    localparam int CW_MAX  = 32;
    localparam int NCH_MIN = 1;
    localparam int NCH_MAX = 32;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    // Counter width clamped into the supported range.
    function automatic int count_w(input int cw);
        if (cw < CW_MIN) begin
            return CW_MIN;
        end
        if (cw > CW_MAX) begin
            return CW_MAX;
        end
        return cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/busy_timer_chan.sv
`default_nettype none
// ============================================================================
// Module   : busy_timer_chan
// Brief    : One busy-timer channel: count, latched period, mode, done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module busy_timer_chan
    import busy_timer_pkg::*;
#(
    parameter  int CW     = 8,
    parameter  int RETRIG = 0,
    localparam int W      = count_w(CW)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_load,
    input  logic         i_mode,
    input  logic         i_abort,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] period_q;
    logic [W-1:0] period_d;
    mode_e        mode_q;
    mode_e        mode_d;
    logic         done_q;
    logic         done_d;

    logic         w_run;
    logic         w_accept;

    assign w_run    = (count_q != '0);
    assign w_accept = i_start && (i_load != '0) && (!w_run || (RETRIG != 0));

    // Priority: abort, accepted start, expiry, decrement.
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (i_abort) begin
            count_d = '0;
        end else if (w_accept) begin
            count_d  = i_load;
            period_d = i_load;
            mode_d   = mode_e'(i_mode);
        end else if (count_q == c_one) begin
            done_d  = 1'b1;
            count_d = (mode_q == MODE_PERIODIC) ? period_q : '0;
        end else if (w_run) begin
            count_d = count_q - c_one;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign o_busy  = w_run;
    assign o_done  = done_q;
    assign o_count = count_q;

`ifdef FORMAL
    logic prev_done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_done_q <= 1'b0;
        end else begin
            prev_done_q <= done_q;
        end
    end

    always_comb begin
        if (i_rst_n) begin
            a_count_le_period: assert (count_q <= period_q);
            a_no_double_done:  assert (!(done_q && prev_done_q && (period_q > c_one)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/multi_busy_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_busy_timer
// Brief    : NCH independent busy timers with one-shot/periodic modes.
// Revision : 1.0 - initial release
// ============================================================================
module multi_busy_timer
    import busy_timer_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CW     = 8,
    parameter int RETRIG = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NCH-1:0]    i_start,
    input  logic [NCH*CW-1:0] i_load,
    input  logic [NCH-1:0]    i_mode,
    input  logic [NCH-1:0]    i_abort,
    output logic [NCH-1:0]    o_busy,
    output logic [NCH-1:0]    o_done,
    output logic              o_any_busy,
    output logic [NCH*CW-1:0] o_count
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        busy_timer_chan #(
            .CW     (CW),
            .RETRIG (RETRIG)
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_start (i_start[c]),
            .i_load  (i_load[c*CW +: CW]),
            .i_mode  (i_mode[c]),
            .i_abort (i_abort[c]),
            .o_busy  (o_busy[c]),
            .o_done  (o_done[c]),
            .o_count (o_count[c*CW +: CW])
        );
    end

    assign o_any_busy = |o_busy;

endmodule
`default_nettype wire
